// File: rtl/aes_result_serializer_if.sv
// aes_result_serializer_if: block-in / byte-out bundle for the serializer.
// ByteParity exists only when SER_PARITY_EN is defined.
interface aes_result_serializer_if;
  logic [127:0] Result;
  logic         WriteEn;
  logic         WriteRy;
  logic [7:0]   ByteOut;
  logic         ByteValid;
  logic         ByteReady;
  logic         ByteLast;
  logic         Busy;
  logic         Overrun;
  logic         ClearOvr;
`ifdef SER_PARITY_EN
  logic         ByteParity;

  modport master (
    output Result, WriteEn, ByteReady, ClearOvr,
    input  WriteRy, ByteOut, ByteValid, ByteLast,
    input  Busy, Overrun, ByteParity
  );

  modport slave (
    input  Result, WriteEn, ByteReady, ClearOvr,
    output WriteRy, ByteOut, ByteValid, ByteLast,
    output Busy, Overrun, ByteParity
  );
`else
  modport master (
    output Result, WriteEn, ByteReady, ClearOvr,
    input  WriteRy, ByteOut, ByteValid, ByteLast,
    input  Busy, Overrun
  );

  modport slave (
    input  Result, WriteEn, ByteReady, ClearOvr,
    output WriteRy, ByteOut, ByteValid, ByteLast,
    output Busy, Overrun
  );
`endif
endinterface

// File: rtl/aes_result_serializer.sv
// aes_result_serializer: ping-pong 128-bit block buffer emitted bytewise.
// Define SER_PARITY_EN to add the ByteParity output.
module aes_result_serializer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input logic Clk,
  input logic Rst,
  aes_result_serializer_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t       state;
  state_t       state_nx;
  logic [127:0] slot [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic [1:0]   count_nx;
  logic [3:0]   idx;
  logic         overrun;

  logic         write_ry;
  logic         valid;
  logic         capture;
  logic         xfer;
  logic         done;
  logic [3:0]   sel;
  logic [7:0]   cur;
  logic [7:0]   byte_o;

  assign write_ry = (count != 2'd2);
  assign valid    = (state == SHIFT);
  assign capture  = bus.WriteEn & write_ry;
  assign xfer     = valid & bus.ByteReady;
  assign done     = xfer & (idx == 4'hf);

  // byte index 0 maps to the top byte when MSB_FIRST
  assign sel    = MSB_FIRST ? ~idx : idx;
  assign cur    = slot[rd_ptr][{sel, 3'b000} +: 8];
  assign byte_o = valid ? cur : 8'h00;

  always_comb begin
    count_nx = count;
    state_nx = state;
    unique case (1'b1)
      (capture & ~done): count_nx = count + 2'd1;
      (done & ~capture): count_nx = count - 2'd1;
      default:           count_nx = count;
    endcase
    unique case (state)
      IDLE:    if (capture) state_nx = SHIFT;
      SHIFT:   if (count_nx == 2'd0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      count   <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      idx     <= 4'h0;
      overrun <= 1'b0;
    end else begin
      count <= count_nx;
      if (capture) wr_ptr <= ~wr_ptr;
      if (xfer)    idx    <= idx + 4'h1;
      if (done)    rd_ptr <= ~rd_ptr;
      if (bus.WriteEn && !write_ry) overrun <= 1'b1;
      else if (bus.ClearOvr)        overrun <= 1'b0;
    end
  end

  // payload needs no reset: it is only visible while a slot is occupied
  always_ff @(posedge Clk) begin
    if (capture) slot[wr_ptr] <= bus.Result;
  end

  assign bus.WriteRy   = write_ry;
  assign bus.ByteValid = valid;
  assign bus.ByteOut   = byte_o;
  assign bus.ByteLast  = valid & (idx == 4'hf);
  assign bus.Busy      = (count != 2'd0);
  assign bus.Overrun   = overrun;
`ifdef SER_PARITY_EN
  assign bus.ByteParity = ^byte_o;
`endif

endmodule

// File: tb/tb_aes_result_serializer.sv
// tb_aes_result_serializer: scoreboard bench, MSB-first and LSB-first DUTs
// driven in lockstep from the same stimulus.
module tb_aes_result_serializer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] result = '0;
  logic         write_en = 1'b0;
  logic         byte_ready = 1'b1;
  logic         clear_ovr = 1'b0;

  int n_chk = 0;
  int n_bad = 0;
  int xfers_m = 0;

  logic [8:0] q_m[$];
  logic [8:0] q_l[$];
  logic       hold_m = 1'b0;
  logic [8:0] held_m = '0;

  localparam logic [127:0] BLK_A = 128'h3902dc1925dc116a8409850b1dfb9732;
  localparam logic [127:0] BLK_B = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BLK_C = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
  localparam logic [127:0] BLK_D = 128'hdeadbeef0123456789abcdefcafef00d;

  aes_result_serializer_if bus_m ();
  aes_result_serializer_if bus_l ();

  assign bus_m.Result    = result;
  assign bus_m.WriteEn   = write_en;
  assign bus_m.ByteReady = byte_ready;
  assign bus_m.ClearOvr  = clear_ovr;
  assign bus_l.Result    = result;
  assign bus_l.WriteEn   = write_en;
  assign bus_l.ByteReady = byte_ready;
  assign bus_l.ClearOvr  = clear_ovr;

  aes_result_serializer #(.MSB_FIRST(1'b1)) dut_m (
    .Clk (clk),
    .Rst (rst_n),
    .bus (bus_m.slave)
  );

  aes_result_serializer #(.MSB_FIRST(1'b0)) dut_l (
    .Clk (clk),
    .Rst (rst_n),
    .bus (bus_l.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_block(input logic [127:0] blk);
    for (int i = 0; i < 16; i++) begin
      q_m.push_back({i == 15, blk[127 - 8*i -: 8]});
      q_l.push_back({i == 15, blk[8*i +: 8]});
    end
  endtask

  task automatic send(input logic [127:0] blk, input bit accept);
    result   = blk;
    write_en = 1'b1;
    if (accept) push_block(blk);
    tick();
    write_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((bus_m.Busy || q_m.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("idle_timeout", 0, 1);
    check("idle_busy", bus_m.Busy, 0);
    check("idle_qm", q_m.size(), 0);
    check("idle_ql", q_l.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wry"},  bus_m.WriteRy, 1);
    check({tag, "_val"},  bus_m.ByteValid, 0);
    check({tag, "_byte"}, bus_m.ByteOut, 0);
    check({tag, "_last"}, bus_m.ByteLast, 0);
    check({tag, "_busy"}, bus_m.Busy, 0);
    check({tag, "_ovr"},  bus_m.Overrun, 0);
    check({tag, "_lval"}, bus_l.ByteValid, 0);
`ifdef SER_PARITY_EN
    check({tag, "_par"},  bus_m.ByteParity, 0);
`endif
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n) begin
      if (hold_m) begin
        check("hold_valid", bus_m.ByteValid, 1);
        check("hold_byte", {bus_m.ByteLast, bus_m.ByteOut}, held_m);
      end
      hold_m = bus_m.ByteValid && !byte_ready;
      held_m = {bus_m.ByteLast, bus_m.ByteOut};
      if (bus_m.ByteValid && byte_ready) begin
        if (q_m.size() == 0) begin
          check("extra_m", {bus_m.ByteLast, bus_m.ByteOut}, 9'h1ff);
        end else begin
          e = q_m.pop_front();
          check("byte_m", {bus_m.ByteLast, bus_m.ByteOut}, e);
`ifdef SER_PARITY_EN
          check("par_m", bus_m.ByteParity, ^e[7:0]);
`endif
        end
        xfers_m++;
      end
    end else begin
      hold_m = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n && bus_l.ByteValid && byte_ready) begin
      if (q_l.size() == 0) begin
        check("extra_l", {bus_l.ByteLast, bus_l.ByteOut}, 9'h1ff);
      end else begin
        e = q_l.pop_front();
        check("byte_l", {bus_l.ByteLast, bus_l.ByteOut}, e);
`ifdef SER_PARITY_EN
        check("par_l", bus_l.ByteParity, ^e[7:0]);
`endif
      end
    end
  end

  initial begin
    int base;
    int nval;
    int n;

    tick();
    check_reset_outputs("rst_in");
    tick();
    rst_n = 1'b1;
    tick();
    check_reset_outputs("rst_out");

    // single block, always ready
    check("pre_valid", bus_m.ByteValid, 0);
    send(BLK_A, 1'b1);
    check("latency", bus_m.ByteValid, 1);
    check("first_m", bus_m.ByteOut, 8'h39);
    check("first_l", bus_l.ByteOut, 8'h32);
    wait_idle(100);

    // ready toggling every cycle
    base = xfers_m;
    byte_ready = 1'b0;
    send(BLK_B, 1'b1);
    n = 0;
    while ((bus_m.Busy || q_m.size() != 0) && n < 200) begin
      byte_ready = ~byte_ready;
      tick();
      n++;
    end
    byte_ready = 1'b1;
    check("toggle_timeout", n < 200, 1);
    check("toggle_xfers", xfers_m - base, 16);
    wait_idle(10);

    // fill both slots while stalled, third block dropped
    byte_ready = 1'b0;
    send(BLK_C, 1'b1);
    check("wry_one", bus_m.WriteRy, 1);
    send(BLK_D, 1'b1);
    check("wry_full", bus_m.WriteRy, 0);
    check("ovr_before", bus_m.Overrun, 0);
    send(BLK_A, 1'b0);
    check("ovr_set", bus_m.Overrun, 1);
    clear_ovr = 1'b1;
    send(BLK_B, 1'b0);
    clear_ovr = 1'b0;
    check("ovr_set_wins", bus_m.Overrun, 1);
    tick();
    check("ovr_hold", bus_m.Overrun, 1);
    check("busy_full", bus_m.Busy, 1);
    byte_ready = 1'b1;
    nval = 0;
    for (int i = 0; i < 32; i++) begin
      if (bus_m.ByteValid) nval++;
      tick();
    end
    check("no_bubble", nval, 32);
    check("drain_busy", bus_m.Busy, 0);
    check("ovr_after", bus_m.Overrun, 1);
    clear_ovr = 1'b1;
    tick();
    clear_ovr = 1'b0;
    check("ovr_clear", bus_m.Overrun, 0);
    wait_idle(10);

    // reset after byte 5
    base = xfers_m;
    send(BLK_D, 1'b1);
    n = 0;
    while (xfers_m < base + 6 && n < 50) begin
      tick();
      n++;
    end
    check("mid_timeout", n < 50, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    q_m.delete();
    q_l.delete();
    tick();
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    tick();
    check_reset_outputs("rst_rel");
    send(BLK_C, 1'b1);
    check("post_first", bus_m.ByteOut, 8'hf0);
    wait_idle(100);

    $display("%0d/%0d checks passed", n_chk - n_bad, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_result_serializer.md
AES_RESULT_SERIALIZER -- requirements
Module: aes_result_serializer

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1, selecting byte order (1: Result[127:120] sent first; 0: Result[7:0] sent first).
REQ-002 SHALL have port Clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port Rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Result  input  128  ciphertext/plaintext block from the AES core.
REQ-005 SHALL have port WriteEn  input  1  one-cycle strobe: Result valid this cycle.
REQ-006 SHALL have port WriteRy  output  1  high when a block buffer slot is free.
REQ-007 SHALL have port ByteOut  output  8  current output byte.
REQ-008 SHALL have port ByteValid  output  1  ByteOut holds a valid byte.
REQ-009 SHALL have port ByteReady  input  1  downstream accepts the byte; transfer = ByteValid & ByteReady.
REQ-010 SHALL have port ByteLast  output  1  high with ByteValid on byte 15 of a block.
REQ-011 SHALL have port Busy  output  1  high when occupancy is nonzero.
REQ-012 SHALL have port Overrun  output  1  sticky: a block was dropped.
REQ-013 SHALL have port ClearOvr  input  1  synchronous clear of Overrun.

Function
REQ-014 SHALL hold two 128-bit block slots (ping-pong) with occupancy count 0..2; WriteRy = (count < 2), decoded from registered state only.
REQ-015 SHALL capture Result into the write slot on a cycle where WriteEn=1 and WriteRy=1.
REQ-016 SHALL use FSM states IDLE (count=0, ByteValid=0) and SHIFT (ByteValid=1); IDLE->SHIFT on capture; SHIFT->IDLE after byte 15 is transferred with no other slot full.
REQ-017 SHALL present byte 0 of a captured block in the cycle after capture when IDLE (latency 1 cycle, WriteEn to ByteValid).
REQ-018 SHALL hold ByteOut and ByteLast stable while ByteValid=1 and ByteReady=0.
REQ-019 SHALL advance a 4-bit byte index on each transfer; after index 15 transfers, it SHALL wrap to 0, free that slot and, if the other slot is full, present that block's byte 0 in the next cycle with no bubble.
REQ-020 SHALL keep count unchanged when a capture and a block completion occur in the same cycle.
REQ-021 SHALL drop the block and set Overrun when WriteEn=1 and WriteRy=0; when set and ClearOvr coincide, set SHALL win.
REQ-022 SHALL keep Overrun unchanged when WriteEn=0 and ClearOvr=0.

Reset
REQ-023 On Rst=0 SHALL immediately force: WriteRy=1, ByteOut=8'h00, ByteValid=0, ByteLast=0, Busy=0, Overrun=0, count=0, index=0, FSM=IDLE.
REQ-024 Reset mid-block SHALL discard all buffered and partially sent data; no byte from a pre-reset block SHALL appear after release.

Configuration
REQ-025 With macro SER_PARITY_EN defined, SHALL add output port ByteParity (1 bit) = XOR of ByteOut bits, valid with ByteValid, 0 in reset.
REQ-026 Without SER_PARITY_EN, ByteParity SHALL not exist and all other behaviour SHALL be identical.

Verification
REQ-027 Reset, then WriteEn for one cycle with Result=128'h3902dc1925dc116a8409850b1dfb9732, ByteReady=1 -> ByteValid next cycle, 16 consecutive bytes 39,02,dc,...,97,32, ByteLast on 0x32, then Busy=0.
REQ-028 Same block with MSB_FIRST=0 -> first byte 0x32, last byte 0x39.
REQ-029 ByteReady toggled 1/0 every cycle -> ByteOut stable during stalls, exactly 16 transfers, no repeats or skips.
REQ-030 ByteReady=0, three WriteEn strobes on consecutive cycles -> WriteRy low after second, Overrun=1 after third; ByteReady=1 then -> only the first two blocks out, back-to-back with no gap; ClearOvr pulse -> Overrun=0.
REQ-031 Assert Rst=0 after byte 5 of a block -> all outputs at reset values that cycle; after release, new block starts at byte 0.
REQ-032 With SER_PARITY_EN, byte 0x39 -> ByteParity=0; byte 0x32 -> ByteParity=1.
